// File: rtl/clk_rate_monitor.sv
// clk_rate_monitor: synchronizes a slow clock, measures its half-periods and reports lock/error against an expected rate
module clk_rate_monitor #(
    parameter int EXP_HALF = 4,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 8
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          EN,
    input  logic          SIN,
    input  logic          ERR_CLR,
    output logic          SIN_SYNC,
    output logic          RISE,
    output logic          FALL,
    output logic [CW-1:0] HALF_PER,
    output logic          LOCKED,
    output logic          ERR
);
    typedef enum logic [1:0] {IDLE, ACQ, CHECK, LOCK} state_t;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] LO = CW'(EXP_HALF - TOL);
    localparam logic [CW-1:0] HI = CW'(EXP_HALF + TOL);
    localparam logic [CW-1:0] TO = CW'(EXP_HALF + TOL + 1);
    localparam logic [GW-1:0] LC = GW'(LOCK_CNT);
    state_t        state;
    logic          s1, s2, s3;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          edg, good, timeout, bad;
    assign SIN_SYNC = s2;
    assign edg      = RISE | FALL;
    assign good     = cnt >= LO && cnt <= HI;
    // cnt passes TO only once per stall, so the timeout is naturally single-shot
    assign timeout  = cnt == TO && !edg;
    assign bad      = edg ? !good : timeout;
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            RISE     <= 1'b0;
            FALL     <= 1'b0;
            cnt      <= '0;
            gcnt     <= '0;
            HALF_PER <= '0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            state    <= IDLE;
        end else begin
            s1   <= SIN;
            s2   <= s1;
            s3   <= s2;
            RISE <= s2 & ~s3;
            FALL <= ~s2 & s3;
            if (!EN) begin
                state  <= IDLE;
                cnt    <= '0;
                gcnt   <= '0;
                LOCKED <= 1'b0;
                ERR    <= ERR & ~ERR_CLR;
            end else begin
                cnt <= edg ? CW'(1) : (&cnt ? cnt : cnt + 1'b1);
                if (edg && (state == CHECK || state == LOCK))
                    HALF_PER <= cnt;
                ERR <= (state == LOCK && bad) | (ERR & ~ERR_CLR);
                case (state)
                    IDLE: state <= ACQ;
                    ACQ: begin
                        if (edg) begin
                            state <= CHECK;
                            gcnt  <= '0;
                        end
                    end
                    CHECK: begin
                        if (edg && good) begin
                            gcnt <= gcnt + 1'b1;
                            if (gcnt + 1'b1 == LC) begin
                                state  <= LOCK;
                                LOCKED <= 1'b1;
                            end
                        end else if (bad) begin
                            gcnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (bad) begin
                            LOCKED <= 1'b0;
                            gcnt   <= '0;
                            state  <= CHECK;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_clk_rate_monitor.sv
// tb_clk_rate_monitor: directed stimulus with an edge-driven scoreboard for clk_rate_monitor
module tb_clk_rate_monitor;
    logic       CLK, RES, EN, SIN, ERR_CLR;
    logic       SIN_SYNC, RISE, FALL, LOCKED, ERR;
    logic [7:0] HALF_PER;
    int         n_chk = 0;
    int         n_fail = 0;
    typedef struct {
        logic       r;
        logic [7:0] hp;
        logic       lk;
        logic       er;
    } exp_t;
    exp_t q[$];
    exp_t me;
    logic mr;

    clk_rate_monitor dut (
        .CLK(CLK), .RES(RES), .EN(EN), .SIN(SIN), .ERR_CLR(ERR_CLR),
        .SIN_SYNC(SIN_SYNC), .RISE(RISE), .FALL(FALL), .HALF_PER(HALF_PER),
        .LOCKED(LOCKED), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic push(input logic r, input int hp, input logic lk, input logic er);
        q.push_back(exp_t'{r, 8'(hp), lk, er});
    endtask

    // hp/lk/er describe the state expected right after this toggle's edge is processed
    task automatic tog(input int n, input int hp, input logic lk, input logic er);
        SIN = ~SIN;
        push(SIN, hp, lk, er);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sin_sync"}, SIN_SYNC, 0);
        chk({tag, "_rise"}, RISE, 0);
        chk({tag, "_fall"}, FALL, 0);
        chk({tag, "_half_per"}, HALF_PER, 0);
        chk({tag, "_locked"}, LOCKED, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    // Each edge pulse is checked one cycle later, once its effect on the registers is visible
    initial begin
        forever begin
            @(negedge CLK);
            if (RES && (RISE || FALL)) begin
                mr = RISE;
                @(negedge CLK);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_edge: got edge rise=%0b with empty queue at %0t", mr, $time);
                end else begin
                    me = q.pop_front();
                    chk("edge_dir", mr, me.r);
                    chk("edge_half_per", HALF_PER, me.hp);
                    chk("edge_locked", LOCKED, me.lk);
                    chk("edge_err", ERR, me.er);
                end
            end
        end
    end

    initial begin
        RES = 1'b0; EN = 1'b0; SIN = 1'b0; ERR_CLR = 1'b0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RES = 1'b1;
        @(negedge CLK);
        EN = 1'b1;
        repeat (2) @(negedge CLK);
        // first edge: latency check, then discarded by ACQ
        SIN = 1'b1;
        push(1, 0, 0, 0);
        repeat (2) @(negedge CLK);
        chk("rise_latency_2", RISE, 0);
        @(negedge CLK);
        chk("rise_latency_3", RISE, 1);
        @(negedge CLK);
        repeat (3) tog(4, 4, 0, 0);
        tog(4, 4, 1, 0);
        tog(4, 4, 1, 0);
        // stall while locked
        SIN = ~SIN;
        push(SIN, 4, 1, 0);
        repeat (9) @(negedge CLK);
        chk("stall_locked_before", LOCKED, 1);
        @(negedge CLK);
        chk("stall_locked_after", LOCKED, 0);
        chk("stall_err_after", ERR, 1);
        repeat (10) @(negedge CLK);
        tog(4, 20, 0, 1);
        repeat (3) tog(4, 4, 0, 1);
        tog(4, 4, 1, 1);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("err_clr", ERR, 0);
        chk("err_clr_locked", LOCKED, 1);
        EN = 1'b0;
        @(negedge CLK);
        chk("en_off_locked", LOCKED, 0);
        chk("en_off_err", ERR, 0);
        chk("en_off_half_per", HALF_PER, 4);
        repeat (2) @(negedge CLK);
        EN = 1'b1;
        repeat (2) @(negedge CLK);
        // jitter 3/5 locks, a single 7 breaks it
        tog(3, 4, 0, 0);
        tog(5, 3, 0, 0);
        tog(3, 5, 0, 0);
        tog(5, 3, 0, 0);
        tog(3, 5, 1, 0);
        tog(7, 3, 1, 0);
        tog(4, 7, 0, 1);
        repeat (3) tog(4, 4, 0, 1);
        tog(4, 4, 1, 1);
        // error set coincides with ERR_CLR: set wins
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("clr_before_race", ERR, 0);
        repeat (3) @(negedge CLK);
        chk("race_locked_before", LOCKED, 1);
        @(negedge CLK);
        ERR_CLR = 1'b1;
        @(negedge CLK);
        chk("race_err_set_wins", ERR, 1);
        chk("race_locked", LOCKED, 0);
        @(negedge CLK);
        chk("race_err_cleared", ERR, 0);
        ERR_CLR = 1'b0;
        // period 6 never locks
        tog(6, 11, 0, 0);
        repeat (6) tog(6, 6, 0, 0);
        chk("slow_locked", LOCKED, 0);
        chk("slow_err", ERR, 0);
        // lock, then asynchronous reset between clock edges
        tog(4, 6, 0, 0);
        repeat (3) tog(4, 4, 0, 0);
        tog(4, 4, 1, 0);
        #2 RES = 1'b0;
        #1 chk_zero("async_reset");
        SIN = 1'b1;
        repeat (2) @(negedge CLK);
        RES = 1'b1;
        push(1, 0, 0, 0);
        repeat (4) @(negedge CLK);
        repeat (3) tog(4, 4, 0, 0);
        tog(4, 4, 1, 0);
        repeat (2) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
